// File: rtl/driver_cmd_master.sv
// driver_cmd_master: executes one register command at a time (write, read,
// or poll-until-match) against a simple strobe-based responder and returns a
// single response per accepted command.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only when idle)
//   cmd_op/addr/data/mask      command fields (op: 00 wr, 01 rd, 10 poll, 11 rsvd)
//   cmd_timeout                maximum poll reads (0 behaves as 1)
//   addr_fifo_almost_full      throttles writes to FIFO_ADDR
//   slave_addr/slave_data_in   address / write data toward the responder
//   slave_rd/slave_wr          one-cycle read / write strobes
//   slave_data_out             responder read data, RD_LATENCY after strobe
//   rsp_valid/rsp_ready        response handshake
//   rsp_data/rsp_status        response payload (status 00 ok, 01 timeout, 10 illegal)
//   busy                       high whenever not idle
module driver_cmd_master #(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned POLL_GAP   = 4,
  parameter logic [31:0] FIFO_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [31:0] cmd_mask,
  input  logic [15:0] cmd_timeout,
  input  logic        addr_fifo_almost_full,
  output logic [31:0] slave_addr,
  output logic        slave_rd,
  output logic        slave_wr,
  output logic [31:0] slave_data_in,
  input  logic [31:0] slave_data_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_status,
  output logic        busy
);

  localparam int unsigned DW = 32;
  localparam int unsigned TW = 16;
  localparam int unsigned LW = 3;
  localparam int unsigned GW = 8;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ILLEGAL = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_RD = 3'd2,
    CHECK   = 3'd3,
    GAP     = 3'd4,
    RESP    = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [DW-1:0]   mask_q, mask_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [TW-1:0]   attempts_q, attempts_d;
  logic [LW-1:0]   wait_q, wait_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic [DW-1:0]   addr_d, wdata_d, rsp_data_d;
  logic [1:0]      rsp_status_d;
  logic            issue_go, issue_wr;
  logic            fifo_wr_q;
  logic [TW-1:0]   poll_limit;

  // Latched command is a throttled write when it targets the address FIFO.
  assign fifo_wr_q  = (op_q == OP_WRITE) && (slave_addr == FIFO_ADDR);
  assign poll_limit = (tmo_q == '0) ? TW'(1) : tmo_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and next-output logic. Strobes are decided one cycle ahead so
  // they are registered yet coincide with an ISSUE cycle.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = slave_addr;
    wdata_d      = slave_data_in;
    mask_d       = mask_q;
    tmo_d        = tmo_q;
    attempts_d   = attempts_q;
    wait_d       = wait_q;
    gap_d        = gap_q;
    rd_data_d    = rd_data_q;
    rsp_data_d   = rsp_data;
    rsp_status_d = rsp_status;
    issue_go     = 1'b0;
    issue_wr     = (op_q == OP_WRITE);

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d       = cmd_op;
          addr_d     = cmd_addr;
          wdata_d    = cmd_data;
          mask_d     = cmd_mask;
          tmo_d      = cmd_timeout;
          attempts_d = '0;
          if (cmd_op == OP_RSVD) begin
            state_d      = RESP;
            rsp_data_d   = '0;
            rsp_status_d = ST_ILLEGAL;
          end else begin
            state_d  = ISSUE;
            issue_wr = (cmd_op == OP_WRITE);
            issue_go = !(issue_wr && (cmd_addr == FIFO_ADDR) && addr_fifo_almost_full);
          end
        end
      end

      ISSUE: begin
        if (slave_rd || slave_wr) begin
          if (op_q == OP_WRITE) begin
            state_d      = RESP;
            rsp_data_d   = slave_data_in;
            rsp_status_d = ST_OK;
          end else begin
            state_d = WAIT_RD;
            wait_d  = LW'(1);
          end
        end else begin
          // Stalled FIFO write: strobe the cycle after almost_full is seen low.
          issue_go = !(fifo_wr_q && addr_fifo_almost_full);
        end
      end

      WAIT_RD: begin
        if (wait_q == LW'(RD_LATENCY)) begin
          rd_data_d = slave_data_out;
          if (op_q == OP_WRITE + 2'd1) begin
            state_d      = RESP;
            rsp_data_d   = slave_data_out;
            rsp_status_d = ST_OK;
          end else begin
            state_d = CHECK;
          end
        end else begin
          wait_d = wait_q + LW'(1);
        end
      end

      CHECK: begin
        if (((rd_data_q ^ slave_data_in) & mask_q) == '0) begin
          state_d      = RESP;
          rsp_data_d   = rd_data_q;
          rsp_status_d = ST_OK;
        end else begin
          // Terminal compare uses the pre-increment count, so no wrap.
          attempts_d = attempts_q + TW'(1);
          if (attempts_q == poll_limit - TW'(1)) begin
            state_d      = RESP;
            rsp_data_d   = rd_data_q;
            rsp_status_d = ST_TIMEOUT;
          end else if (POLL_GAP == 0) begin
            state_d  = ISSUE;
            issue_go = 1'b1;
          end else begin
            state_d = GAP;
            gap_d   = GW'(1);
          end
        end
      end

      GAP: begin
        if (gap_q == GW'(POLL_GAP)) begin
          state_d  = ISSUE;
          issue_go = 1'b1;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q          <= '0;
      mask_q        <= '0;
      tmo_q         <= '0;
      attempts_q    <= '0;
      wait_q        <= '0;
      gap_q         <= '0;
      rd_data_q     <= '0;
      cmd_ready     <= 1'b0;
      busy          <= 1'b0;
      slave_addr    <= '0;
      slave_data_in <= '0;
      slave_rd      <= 1'b0;
      slave_wr      <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_status    <= '0;
    end else begin
      op_q          <= op_d;
      mask_q        <= mask_d;
      tmo_q         <= tmo_d;
      attempts_q    <= attempts_d;
      wait_q        <= wait_d;
      gap_q         <= gap_d;
      rd_data_q     <= rd_data_d;
      cmd_ready     <= (state_d == IDLE);
      busy          <= (state_d != IDLE);
      slave_addr    <= addr_d;
      slave_data_in <= wdata_d;
      slave_rd      <= issue_go && !issue_wr;
      slave_wr      <= issue_go && issue_wr;
      rsp_valid     <= (state_d == RESP);
      rsp_data      <= rsp_data_d;
      rsp_status    <= rsp_status_d;
    end
  end

endmodule

// File: tb/tb_driver_cmd_master.sv
// tb_driver_cmd_master: randomized and directed commands checked against a
// cycle-count / outcome model derived from the command rules.
module tb_driver_cmd_master;

  localparam int unsigned L_P = 1;
  localparam int unsigned G_P = 3;
  localparam logic [31:0] FIFO_ADDR_P = 32'h0000_0000;
  localparam int L = int'(L_P);
  localparam int G = int'(G_P);

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_POLL = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr, cmd_data, cmd_mask;
  logic [15:0] cmd_timeout;
  logic        addr_fifo_almost_full;
  logic [31:0] slave_addr, slave_data_in, slave_data_out;
  logic        slave_rd, slave_wr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        busy;

  driver_cmd_master #(
    .RD_LATENCY(L_P),
    .POLL_GAP  (G_P),
    .FIFO_ADDR (FIFO_ADDR_P)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_op                (cmd_op),
    .cmd_addr              (cmd_addr),
    .cmd_data              (cmd_data),
    .cmd_mask              (cmd_mask),
    .cmd_timeout           (cmd_timeout),
    .addr_fifo_almost_full (addr_fifo_almost_full),
    .slave_addr            (slave_addr),
    .slave_rd              (slave_rd),
    .slave_wr              (slave_wr),
    .slave_data_in         (slave_data_in),
    .slave_data_out        (slave_data_out),
    .rsp_valid             (rsp_valid),
    .rsp_ready             (rsp_ready),
    .rsp_data              (rsp_data),
    .rsp_status            (rsp_status),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          c;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] din;
  } strobe_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  strobe_t     strobes[$];
  logic [31:0] cmd_vals[$];
  logic [31:0] rd_vals[$];
  int          rd_cd    = -1;
  logic [31:0] rd_val   = '0;
  bit          af_mode  = 0;
  int          af_until = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Per-cycle observation at the falling edge: responder, strobe log, invariants.
  task automatic monitor();
    if (rd_cd > 0) rd_cd--;
    if (rd_cd == 0) begin
      slave_data_out = rd_val;
      rd_cd = -1;
    end else begin
      slave_data_out = ~rd_val;
    end
    if (reset && slave_rd) begin
      rd_val = (rd_vals.size() > 0) ? rd_vals.pop_front() : $urandom;
      rd_cd  = L;
    end
    if (slave_rd || slave_wr)
      strobes.push_back('{cyc, slave_rd, slave_wr, slave_addr, slave_data_in});
    if (reset) begin
      check("rd_wr_exclusive", 32'(slave_rd & slave_wr), 32'd0);
      check("busy_vs_ready", 32'(busy), 32'(!cmd_ready));
    end
    addr_fifo_almost_full = af_mode ? (cyc < af_until) : 1'($urandom);
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic check_rst_vals();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_slave_rd", 32'(slave_rd), 32'd0);
    check("rst_slave_wr", 32'(slave_wr), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_slave_addr", slave_addr, 32'd0);
    check("rst_slave_data_in", slave_data_in, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_status", 32'(rsp_status), 32'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    rd_cd = -1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    af_mode = 0;
    repeat (3) step();
    reset = 1'b1;
    step();
  endtask

  // Issue one command, predict its strobes and response, then check them.
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] mask, input logic [15:0] tmo,
                         input int af_cycles, input int hold);
    int          a, n, lim, rsp_cyc, exp_rsp, first;
    bit          matched, fifo_wr;
    logic [31:0] v, exp_data;
    logic [1:0]  exp_status;
    int          exp_cyc[$];

    n = 0;
    while (!cmd_ready && n < 100) begin step(); n++; end
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);

    a        = cyc;
    fifo_wr  = (op == OP_WR) && (addr == FIFO_ADDR_P);
    first    = a + 1 + (fifo_wr ? af_cycles : 0);
    exp_data = '0;
    exp_status = 2'b00;
    exp_rsp  = a + 1;
    case (op)
      OP_WR: begin
        exp_cyc.push_back(first);
        exp_data = data;
        exp_rsp  = first + 1;
      end
      OP_RD: begin
        exp_cyc.push_back(first);
        exp_data = cmd_vals[0];
        exp_rsp  = first + L + 1;
      end
      OP_POLL: begin
        lim = (tmo == 16'd0) ? 1 : int'(tmo);
        matched = 0;
        n = 0;
        v = '0;
        while (n < lim && !matched) begin
          v = (n < cmd_vals.size()) ? cmd_vals[n] : 32'h0;
          exp_cyc.push_back(first + n * (L + G + 2));
          n++;
          if ((v & mask) == (data & mask)) matched = 1;
        end
        exp_data   = v;
        exp_status = matched ? 2'b00 : 2'b01;
        exp_rsp    = exp_cyc[$] + L + 2;
      end
      default: exp_status = 2'b10;
    endcase

    rd_vals = cmd_vals;
    strobes.delete();
    af_mode  = fifo_wr;
    af_until = a + af_cycles;
    addr_fifo_almost_full = fifo_wr ? (af_cycles > 0) : 1'($urandom);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    cmd_mask = mask; cmd_timeout = tmo;
    step();

    rsp_cyc = -1;
    n = 0;
    while (n < 1000) begin
      if (rsp_valid) begin rsp_cyc = cyc; break; end
      // Junk commands while busy must be ignored.
      cmd_valid = 1'($urandom); cmd_op = 2'($urandom);
      cmd_addr = $urandom; cmd_data = $urandom; cmd_mask = $urandom;
      cmd_timeout = 16'($urandom);
      step();
      n++;
    end
    cmd_valid = 1'b0;
    af_mode = 0;
    if (rsp_cyc < 0) begin
      check("rsp_arrive", 32'd0, 32'd1);
      apply_reset();
      return;
    end
    check("rsp_cycle", 32'(rsp_cyc), 32'(exp_rsp));

    for (int h = 0; h <= hold; h++) begin
      check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
      if (op != OP_RSVD) check("rsp_data", rsp_data, exp_data);
      check("rsp_status", 32'(rsp_status), 32'(exp_status));
      rsp_ready = (h == hold);
      step();
    end
    rsp_ready = 1'b0;
    check("rsp_drop", 32'(rsp_valid), 32'd0);
    check("ready_after_rsp", 32'(cmd_ready), 32'd1);

    check("strobe_count", 32'(strobes.size()), 32'(exp_cyc.size()));
    foreach (exp_cyc[i]) begin
      if (i < strobes.size()) begin
        check("strobe_cycle", 32'(strobes[i].c), 32'(exp_cyc[i]));
        check("strobe_kind", 32'({strobes[i].rd, strobes[i].wr}),
              (op == OP_WR) ? 32'd1 : 32'd2);
        check("strobe_addr", strobes[i].addr, addr);
        check("strobe_data", strobes[i].din, data);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_addr, r_data, r_mask, r_v;
    logic [15:0] r_tmo;
    int          r_lim, sel, n;

    reset = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; cmd_mask = '0;
    cmd_timeout = '0; addr_fifo_almost_full = 1'b0; rsp_ready = 1'b0;
    slave_data_out = '0;

    step(); step();
    check_rst_vals();
    reset = 1'b1;
    step();
    check("ready_after_reset", 32'(cmd_ready), 32'd1);
    check("busy_after_reset", 32'(busy), 32'd0);

    // Directed: write, read, throttled FIFO write.
    cmd_vals.delete();
    run_cmd(OP_WR, 32'h4, 32'h1, 32'h0, 16'd0, 0, 0);
    cmd_vals = '{32'h0000_0001};
    run_cmd(OP_RD, 32'h100, 32'h0, 32'h0, 16'd0, 0, 1);
    cmd_vals.delete();
    run_cmd(OP_WR, 32'h0, 32'hCAFE_0001, 32'h0, 16'd0, 10, 0);

    // Directed polls: match on third read, timeout of 3, timeout 0.
    cmd_vals = '{32'h0000_0003, 32'h0000_0001, 32'h8000_0000};
    run_cmd(OP_POLL, 32'h100, 32'h0, 32'h1, 16'd5, 0, 2);
    cmd_vals = '{32'h1, 32'h3, 32'h5, 32'h7};
    run_cmd(OP_POLL, 32'h100, 32'h0, 32'h1, 16'd3, 0, 0);
    cmd_vals = '{32'h5, 32'h7};
    run_cmd(OP_POLL, 32'h100, 32'h0, 32'h1, 16'd0, 0, 0);

    // Directed: reserved op.
    cmd_vals.delete();
    run_cmd(OP_RSVD, 32'h200, 32'h1234, 32'h0, 16'd0, 0, 1);

    // Randomized commands.
    for (int k = 0; k < 40; k++) begin
      sel    = int'($urandom_range(0, 9));
      r_op   = (sel < 3) ? OP_WR : (sel < 6) ? OP_RD : (sel < 9) ? OP_POLL : OP_RSVD;
      r_addr = ($urandom_range(0, 3) == 0) ? FIFO_ADDR_P : $urandom;
      r_data = $urandom;
      r_mask = $urandom;
      r_tmo  = 16'($urandom_range(0, 4));
      r_lim  = (r_tmo == 16'd0) ? 1 : int'(r_tmo);
      cmd_vals.delete();
      for (int i = 0; i <= r_lim; i++) begin
        r_v = $urandom;
        if ($urandom_range(0, 2) == 0) r_v = (r_v & ~r_mask) | (r_data & r_mask);
        cmd_vals.push_back(r_v);
      end
      run_cmd(r_op, r_addr, r_data, r_mask, r_tmo,
              int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
    end

    // Reset while waiting for read data aborts the command.
    cmd_vals = '{32'hDEAD_0001};
    rd_vals = cmd_vals;
    cmd_valid = 1'b1; cmd_op = OP_RD; cmd_addr = 32'h100; cmd_data = 32'h55;
    cmd_mask = '0; cmd_timeout = '0;
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (!slave_rd && n < 20) begin step(); n++; end
    check("abort_rd_seen", 32'(slave_rd), 32'd1);
    step();
    reset = 1'b0;
    #1;
    check_rst_vals();
    rd_cd = -1;
    strobes.delete();
    step(); step();
    reset = 1'b1;
    step();
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
      step();
    end
    check("abort_no_strobe", 32'(strobes.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
